exec_sched: RTL and testbench

Two-port round-robin scheduler that shares the single `execute` ALU between two requesters. It accepts one command at a time with a valid/ready handshake, drives the ALU's enable/opcode/operands for exactly one cycle, and captures the registered result on the single cycle it is valid. It returns result, overflow and error to the originating requester with a valid/ready response handshake. It sits between the lab's command sources (bench drivers or a CPU model) and the `execute` instance.

---
 rtl/exec_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 15 +
 rtl/exec_sched.sv | 157 +++++++++++++++
 tb/tb_exec_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute-unit scheduler and the execute ALU.
package exec_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_OP_W   = 8;
    localparam int unsigned DEF_MAX_OP = 7;

    localparam logic [DEF_OP_W-1:0] OP_CLR  = 8'd0;
    localparam logic [DEF_OP_W-1:0] OP_ADD  = 8'd1;
    localparam logic [DEF_OP_W-1:0] OP_SUB  = 8'd2;
    localparam logic [DEF_OP_W-1:0] OP_MUL  = 8'd3;
    localparam logic [DEF_OP_W-1:0] OP_XOR  = 8'd4;
    localparam logic [DEF_OP_W-1:0] OP_AND  = 8'd5;
    localparam logic [DEF_OP_W-1:0] OP_LOR  = 8'd6;
    localparam logic [DEF_OP_W-1:0] OP_NAND = 8'd7;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester that did not win last time wins a tie.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] gnt,
    output logic       any_gnt
);

    always_comb begin
        gnt[0]  = valid[0] & (~valid[1] | last_grant);
        gnt[1]  = valid[1] & (~valid[0] | ~last_grant);
        any_gnt = |valid;
    end

endmodule

// File: rtl/exec_sched.sv
// Shares one registered execute ALU between two requesters, one command in flight at a time.
module exec_sched
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned OP_W   = DEF_OP_W,
    parameter int unsigned MAX_OP = DEF_MAX_OP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_opcode,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_opcode,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_overflow,
    output logic              rsp0_error,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_overflow,
    output logic              rsp1_error,
    output logic              ex_enable,
    output logic [OP_W-1:0]   ex_opcode,
    output logic [DATA_W-1:0] ex_operand1,
    output logic [DATA_W-1:0] ex_operand2,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_overflow,
    input  logic              ex_done
);

    localparam logic [OP_W-1:0] MAX_OP_V = OP_W'(MAX_OP);

    state_t            state_q, state_d;
    logic              last_grant_q;
    logic              gnt_idx_q;
    logic [1:0]        gnt;
    logic              any_gnt;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic              accept;
    logic              rsp_done;
    logic [OP_W-1:0]   sel_opcode;
    logic [DATA_W-1:0] sel_op1;
    logic [DATA_W-1:0] sel_op2;
    logic              sel_legal;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_overflow_q;
    logic              rsp_error_q;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .any_gnt    (any_gnt)
    );

    assign sel_opcode = gnt[1] ? req1_opcode : req0_opcode;
    assign sel_op1    = gnt[1] ? req1_op1    : req0_op1;
    assign sel_op2    = gnt[1] ? req1_op2    : req0_op2;
    assign sel_legal  = (sel_opcode != '0) && (sel_opcode <= MAX_OP_V);
    assign rsp_ready  = {rsp1_ready, rsp0_ready};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready is gated by reset so nothing reads as accepted while reset is held.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_gnt && !reset) begin
                    req_ready = gnt;
                    accept    = 1'b1;
                    state_d   = sel_legal ? ISSUE : RESP;
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP: begin
                rsp_valid[gnt_idx_q] = 1'b1;
                if (rsp_ready[gnt_idx_q]) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The ex_* registers double as the latched command; illegal opcodes leave them untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q   <= 1'b1;
            gnt_idx_q      <= 1'b0;
            ex_enable      <= 1'b0;
            ex_opcode      <= '0;
            ex_operand1    <= '0;
            ex_operand2    <= '0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_error_q    <= 1'b0;
        end else begin
            ex_enable <= accept && sel_legal;
            if (accept) begin
                gnt_idx_q <= gnt[1];
                if (sel_legal) begin
                    ex_opcode   <= sel_opcode;
                    ex_operand1 <= sel_op1;
                    ex_operand2 <= sel_op2;
                end else begin
                    rsp_result_q   <= '0;
                    rsp_overflow_q <= 1'b0;
                    rsp_error_q    <= 1'b1;
                end
            end
            if (state_q == CAPTURE) begin
                rsp_result_q   <= ex_result;
                rsp_overflow_q <= ex_overflow;
                rsp_error_q    <= ~ex_done;
            end
            if (rsp_done) begin
                last_grant_q <= gnt_idx_q;
            end
        end
    end

    assign req0_ready    = req_ready[0];
    assign req1_ready    = req_ready[1];
    assign rsp0_valid    = rsp_valid[0];
    assign rsp1_valid    = rsp_valid[1];
    assign rsp0_result   = rsp_result_q;
    assign rsp1_result   = rsp_result_q;
    assign rsp0_overflow = rsp_overflow_q;
    assign rsp1_overflow = rsp_overflow_q;
    assign rsp0_error    = rsp_error_q;
    assign rsp1_error    = rsp_error_q;

endmodule

// File: tb/tb_exec_sched.sv
// Directed bench for exec_sched with a small registered execute-ALU stand-in.
module tb_exec_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0]  req0_opcode, req1_opcode;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic        rsp0_valid, rsp0_ready, rsp0_overflow, rsp0_error;
    logic        rsp1_valid, rsp1_ready, rsp1_overflow, rsp1_error;
    logic [31:0] rsp0_result, rsp1_result;
    logic        ex_enable;
    logic [7:0]  ex_opcode;
    logic [31:0] ex_operand1, ex_operand2;
    logic [31:0] ex_result;
    logic        ex_overflow, ex_done;
    logic        no_done;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    always #5 clk = ~clk;

    exec_sched #(.DATA_W(32), .OP_W(8), .MAX_OP(7)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_overflow(rsp0_overflow), .rsp0_error(rsp0_error),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_overflow(rsp1_overflow), .rsp1_error(rsp1_error),
        .ex_enable(ex_enable), .ex_opcode(ex_opcode),
        .ex_operand1(ex_operand1), .ex_operand2(ex_operand2),
        .ex_result(ex_result), .ex_overflow(ex_overflow), .ex_done(ex_done)
    );

    function automatic logic [32:0] alu_calc(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            8'd1:    return {1'b0, a} + {1'b0, b};
            8'd2:    return {1'b0, a} - {1'b0, b};
            8'd3:    return {1'b0, a} * {1'b0, b};
            8'd4:    return {1'b0, a ^ b};
            8'd5:    return {1'b0, a & b};
            8'd6:    return {1'b0, a | b};
            8'd7:    return {1'b0, ~(a & b)};
            default: return '0;
        endcase
    endfunction

    // Registered ALU: result valid one cycle after enable, zeroed otherwise.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_result   <= '0;
            ex_overflow <= 1'b0;
            ex_done     <= 1'b0;
        end else if (ex_enable) begin
            {ex_overflow, ex_result} <= alu_calc(ex_opcode, ex_operand1, ex_operand2);
            ex_done <= !no_done;
        end else begin
            ex_result   <= '0;
            ex_overflow <= 1'b0;
            ex_done     <= 1'b0;
        end
    end

    task automatic clear_reqs;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_opcode = '0; req1_opcode = '0;
        req0_op1 = '0; req0_op2 = '0; req1_op1 = '0; req1_op2 = '0;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one command from a negedge with both rsp_ready high; returns what was observed.
    task automatic run_op(input logic r, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned lat, output logic rdy, output int unsigned en_cnt,
                          output logic early, output logic vld, output logic [31:0] res,
                          output logic ov, output logic err);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        if (r) begin
            req1_valid = 1'b1; req1_opcode = op; req1_op1 = a; req1_op2 = b;
        end else begin
            req0_valid = 1'b1; req0_opcode = op; req0_op1 = a; req0_op2 = b;
        end
        #1 rdy = r ? req1_ready : req0_ready;
        @(negedge clk);
        clear_reqs();
        #1;
        en_cnt = 0;
        early  = 1'b0;
        for (int unsigned c = 1; c <= lat; c++) begin
            if (c > 1) begin
                @(negedge clk);
                #1;
            end
            if (ex_enable) en_cnt++;
            if (c < lat && (rsp0_valid || rsp1_valid)) early = 1'b1;
        end
        vld = r ? rsp1_valid : rsp0_valid;
        res = r ? rsp1_result : rsp0_result;
        ov  = r ? rsp1_overflow : rsp0_overflow;
        err = r ? rsp1_error : rsp0_error;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, ex_enable} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, ex_enable});
        end
        tests_run++;
        if ({ex_opcode, ex_operand1, ex_operand2, rsp0_result, rsp1_error} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: opcode=%h op1=%h op2=%h result=%h err=%b expected all 0",
                     ex_opcode, ex_operand1, ex_operand2, rsp0_result, rsp1_error);
        end
        clear_reqs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_add;
        logic rdy, en1, en2, v2, v3, ov, err;
        logic [7:0] opc;
        logic [31:0] res;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_opcode = 8'd1; req0_op1 = 32'd5; req0_op2 = 32'd7;
        #1 rdy = req0_ready;
        @(negedge clk);
        clear_reqs();
        #1 en1 = ex_enable; opc = ex_opcode;
        @(negedge clk);
        #1 en2 = ex_enable; v2 = rsp0_valid;
        @(negedge clk);
        #1 v3 = rsp0_valid; res = rsp0_result; ov = rsp0_overflow; err = rsp0_error;
        tests_run++;
        if (rdy !== 1'b1) begin tests_failed++; $display("FAIL add_ready: got %b expected 1", rdy); end
        tests_run++;
        if ({en1, en2, opc} !== {2'b10, 8'd1}) begin
            tests_failed++;
            $display("FAIL add_enable: en T+1=%b T+2=%b opcode=%0d expected 1,0,1", en1, en2, opc);
        end
        tests_run++;
        if ({v2, v3} !== 2'b01) begin
            tests_failed++;
            $display("FAIL add_latency: valid T+2=%b T+3=%b expected 0,1", v2, v3);
        end
        tests_run++;
        if ({res, ov, err} !== {32'd12, 2'b00}) begin
            tests_failed++;
            $display("FAIL add_result: result=%0d ov=%b err=%b expected 12,0,0", res, ov, err);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL add_rsp_drop: got %b expected 0", rsp0_valid); end
        @(negedge clk);
    endtask

    task automatic test_overflow_mul;
        logic rdy, early, vld, ov, err;
        int unsigned en;
        logic [31:0] res;
        run_op(1'b1, 8'd1, 32'hFFFF_FFFF, 32'd1, 3, rdy, en, early, vld, res, ov, err);
        tests_run++;
        if ({rdy, early, vld, res, ov, err} !== {3'b101, 32'd0, 2'b10}) begin
            tests_failed++;
            $display("FAIL add_overflow: rdy=%b early=%b vld=%b result=%h ov=%b err=%b expected 1,0,1,0,1,0",
                     rdy, early, vld, res, ov, err);
        end
        run_op(1'b1, 8'd3, 32'h0000_FFFF, 32'h0000_FFFF, 3, rdy, en, early, vld, res, ov, err);
        tests_run++;
        if ({vld, res, err} !== {1'b1, 32'hFFFE_0001, 1'b0}) begin
            tests_failed++;
            $display("FAIL mul_result: vld=%b result=%h err=%b expected 1,fffe0001,0", vld, res, err);
        end
    endtask

    task automatic test_round_robin;
        int unsigned grants[$];
        int unsigned overlap = 0, wrong = 0, n0 = 0, n1 = 0;
        pulse_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_opcode = 8'd4; req0_op1 = 32'hF0; req0_op2 = 32'h0F;
        req1_valid = 1'b1; req1_opcode = 8'd4; req1_op1 = 32'h3;  req1_op2 = 32'h1;
        for (int unsigned k = 0; k < 18; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp0_valid && rsp1_valid) overlap++;
            if (rsp0_valid) begin n0++; if (rsp0_result !== 32'hFF) wrong++; end
            if (rsp1_valid) begin n1++; if (rsp1_result !== 32'h2) wrong++; end
        end
        clear_reqs();
        repeat (4) @(negedge clk);
        tests_run++;
        if (grants.size() < 4 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
            tests_failed++;
            $display("FAIL rr_order: got %p expected 0,1,0,1,...", grants);
        end
        tests_run++;
        if (overlap != 0 || wrong != 0) begin
            tests_failed++;
            $display("FAIL rr_routing: overlap=%0d wrong_results=%0d expected 0,0", overlap, wrong);
        end
        tests_run++;
        if (n0 != 2 || n1 != 2) begin
            tests_failed++;
            $display("FAIL rr_count: rsp0=%0d rsp1=%0d expected 2,2", n0, n1);
        end
    endtask

    task automatic test_illegal;
        logic rdy, early, vld, ov, err;
        int unsigned en;
        logic [31:0] res;
        run_op(1'b1, 8'd9, 32'd3, 32'd4, 1, rdy, en, early, vld, res, ov, err);
        tests_run++;
        if ({rdy, vld, res, ov, err} !== {2'b11, 32'd0, 2'b01} || en != 0) begin
            tests_failed++;
            $display("FAIL illegal_op9: rdy=%b vld=%b result=%h ov=%b err=%b en=%0d expected 1,1,0,0,1,0",
                     rdy, vld, res, ov, err, en);
        end
        run_op(1'b1, 8'd0, 32'd3, 32'd4, 1, rdy, en, early, vld, res, ov, err);
        tests_run++;
        if ({vld, res, err} !== {1'b1, 32'd0, 1'b1} || en != 0) begin
            tests_failed++;
            $display("FAIL illegal_op0: vld=%b result=%h err=%b en=%0d expected 1,0,1,0", vld, res, err, en);
        end
    endtask

    task automatic test_backpressure;
        logic ok_stable = 1'b1;
        logic early_rdy = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_opcode = 8'd1; req0_op1 = 32'd1; req0_op2 = 32'd2;
        @(negedge clk);
        clear_reqs();
        req1_valid = 1'b1; req1_opcode = 8'd5; req1_op1 = 32'hFF; req1_op2 = 32'h0F;
        for (int unsigned c = 1; c <= 2; c++) begin
            #1 if (req1_ready) early_rdy = 1'b1;
            @(negedge clk);
        end
        for (int unsigned c = 0; c < 5; c++) begin
            #1;
            if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd3 || rsp0_error !== 1'b0 || rsp1_valid !== 1'b0) ok_stable = 1'b0;
            if (req1_ready) early_rdy = 1'b1;
            @(negedge clk);
        end
        rsp0_ready = 1'b1;
        #1;
        if (req1_ready) early_rdy = 1'b1;
        tests_run++;
        if (ok_stable !== 1'b1) begin tests_failed++; $display("FAIL bp_hold: rsp0 stable=%b expected 1", ok_stable); end
        tests_run++;
        if (early_rdy !== 1'b0) begin tests_failed++; $display("FAIL bp_no_grant: req1_ready seen=%b expected 0", early_rdy); end
        @(negedge clk);
        #1;
        tests_run++;
        if ({req1_ready, rsp0_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL bp_next_grant: req1_ready=%b rsp0_valid=%b expected 1,0", req1_ready, rsp0_valid);
        end
        @(negedge clk);
        clear_reqs();
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if ({rsp1_valid, rsp1_result} !== {1'b1, 32'h0F}) begin
            tests_failed++;
            $display("FAIL bp_req1_result: vld=%b result=%h expected 1,0000000f", rsp1_valid, rsp1_result);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        logic rdy, early, vld, ov, err;
        logic any_rsp = 1'b0;
        int unsigned en;
        logic [31:0] res;
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_opcode = 8'd1; req0_op1 = 32'd3; req0_op2 = 32'd4;
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if ({ex_enable, rsp0_valid, rsp1_valid, req0_ready, ex_opcode, ex_operand1, rsp0_result} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: en=%b v0=%b v1=%b opc=%h op1=%h res=%h expected all 0",
                     ex_enable, rsp0_valid, rsp1_valid, ex_opcode, ex_operand1, rsp0_result);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int unsigned c = 0; c < 4; c++) begin
            #1 if (rsp0_valid || rsp1_valid) any_rsp = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (any_rsp !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_no_rsp: got %b expected 0", any_rsp); end
        run_op(1'b0, 8'd2, 32'd10, 32'd3, 3, rdy, en, early, vld, res, ov, err);
        tests_run++;
        if ({rdy, early, vld, res, err} !== {3'b101, 32'd7, 1'b0} || en != 1) begin
            tests_failed++;
            $display("FAIL sub_after_reset: rdy=%b early=%b vld=%b result=%0d err=%b en=%0d expected 1,0,1,7,0,1",
                     rdy, early, vld, res, err, en);
        end
        no_done = 1'b1;
        run_op(1'b0, 8'd1, 32'd1, 32'd1, 3, rdy, en, early, vld, res, ov, err);
        no_done = 1'b0;
        tests_run++;
        if ({vld, err} !== 2'b11) begin
            tests_failed++;
            $display("FAIL no_done_error: vld=%b err=%b expected 1,1", vld, err);
        end
    endtask

    initial begin
        no_done = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        clear_reqs();
        test_reset();
        test_single_add();
        test_overflow_mul();
        test_round_robin();
        test_illegal();
        test_backpressure();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
